mux_scan_n: RTL and testbench
=============================

// Module: mux_scan_n
// PURPOSE
//  Parametrised N:1 multiplexer, W bits per channel, with a registered output and two modes:
//   - manual select: the output follows the sel input.
//   - auto-scan: an internal prescaler and channel counter cycle through the inputs.
//  Successor to the fixed 8:1 32-bit mux. Feeds the seven-segment/LED display path and
//  debug-bus selection in the CPU top level.
// PARAMETERS
//  W    32  data width per channel, >=1
//  N    8   channel count, 2..64; need not be a power of two
//  SW   6   select width, >= clog2(N)
//  DIV  4   prescaler period in clk cycles per scan step, >=1
// PORTS
//  clk         in   1    rising-edge clock
//  rst_n       in   1    asynchronous reset, active-low
//  din         in   N*W  flattened inputs; channel k = din[k*W +: W]
//  sel         in   SW   manual channel select (mode=0)
//  mode        in   1    0 = manual, 1 = auto-scan
//  en          in   1    1 = advance/update; 0 = freeze all state
//  dout        out  W    registered selected channel
//  cur_sel     out  SW   channel index currently shown on dout
//  sel_err     out  1    registered: last manual sel was >= N
//  scan_tick   out  1    1-cycle pulse on the cycle cur_sel advances in scan mode
// BEHAVIOUR
//  Reset (async assert, sync release): dout=0, cur_sel=0, sel_err=0, scan_tick=0,
//   prescaler=0, mode_q=0.
//  en=0: all registers hold, including the prescaler; scan_tick=0.
//  Manual mode (mode=0, en=1). Latency is 1 cycle. At each edge:
//   - cur_sel<=sel.
//   - if sel<N: dout<=din[sel], sel_err<=0.
//   - if sel>=N: dout<=0, sel_err<=1.
//  Scan mode (mode=1, en=1):
//   - Prescaler counts 0..DIV-1. On each edge where prescaler==DIV-1:
//     prescaler<=0, cur_sel<=(cur_sel==N-1)?0:cur_sel+1, scan_tick<=1.
//   - Otherwise prescaler increments and scan_tick<=0.
//   - dout<=din[next cur_sel] every enabled cycle, so dout tracks live data on the
//     channel being shown.
//   - sel_err<=0.
//   - DIV=1: cur_sel advances every enabled cycle and scan_tick stays high.
//  Mode switch (mode_q registers mode; a switch is detected when mode!=mode_q with en=1):
//   - 0->1: prescaler<=0, cur_sel<=0, dout<=din[0], no tick on that edge.
//   - 1->0: takes the manual path immediately, same edge.
//  cur_sel never holds a value >=N in scan mode. Wrap N-1 -> 0 is seamless.
//  din changing mid-cycle: dout reflects the value sampled at the edge only.
//  Reset mid-scan: returns to channel 0 in manual mode; no tick is emitted.
//  Arithmetic: prescaler width = clog2(DIV)+1; comparisons are unsigned; sel is zero-extended.
// CONFIGURATION
//  SCAN_ONEHOT_EN defined:
//   - Adds output an_n [N-1:0], registered and active-low.
//   - an_n[cur_sel]=0, all other bits 1. Updated on the same edge as cur_sel.
//   - Reset value: all 1s. When sel_err=1: all 1s.
//   - Used directly as display anode enables.
//  SCAN_ONEHOT_EN undefined: the port and its logic are absent; the rest is unchanged.
// TESTING
//  Test 1, manual sweep. W=32, N=8, din channel k = k, mode=0, en=1. Drive sel=0..7, one per 5 cycles.
//   -> dout=k exactly 1 cycle after sel=k; cur_sel=k; sel_err=0.
//  Test 2, pattern. Channels alternate 32'h5/32'hA. Sweep sel 0..7.
//   -> dout = 5,A,5,A,5,A,5,A, each 1 cycle after sel.
//  Test 3, scan. DIV=4, mode 0->1.
//   -> cur_sel=0 for 4 cycles, then 1, ... 7, then 0.
//   -> scan_tick pulses every 4th cycle.
//   -> dout=cur_sel value.
//  Test 4, out of range. N=6 build, sel=7.
//   -> next cycle: dout=0, sel_err=1, an_n=6'b111111 (if SCAN_ONEHOT_EN).
//   -> then sel=2: dout=2, sel_err=0.
//  Test 5, freeze and reset. Scan mode, at cur_sel=3, en=0 for 10 cycles.
//   -> cur_sel stays 3, no tick.
//   -> en=1: the remaining prescaler count resumes.
//   -> assert rst_n=0 mid-cycle: dout=0 and cur_sel=0 immediately, without waiting for clk.
//  Test 6, one-hot (SCAN_ONEHOT_EN). N=4 scan.
//   -> an_n = 1110, 1101, 1011, 0111, 1110, aligned with cur_sel.

Source files
------------

// File: rtl/mux_scan_n.sv
// N:1 registered multiplexer with manual select and auto-scan modes.
// Optional `SCAN_ONEHOT_EN adds active-low one-hot anode output an_n.
module mux_scan_n #(
  parameter int W   = 32,
  parameter int N   = 8,
  parameter int SW  = 6,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  cur_sel,
  output logic           sel_err,
  output logic           scan_tick
`ifdef SCAN_ONEHOT_EN
  ,
  output logic [N-1:0]   an_n
`endif
);

  localparam int PW = $clog2(DIV) + 1;
  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);
  localparam logic [SW:0]   NV    = (SW+1)'(N);

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mode_e;

  mode_e         mode_q,    mode_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [W-1:0]  dout_q,    dout_d;
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic          sel_err_q, sel_err_d;
  logic          tick_q,    tick_d;
  logic          sel_ok;

  // Out-of-range indices yield zero, which is exactly the manual-mode error value.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input logic [SW-1:0] idx);
    pick = '0;
    for (int unsigned k = 0; k < N; k++)
      if (idx == SW'(k)) pick = d[k*W +: W];
  endfunction

  assign sel_ok = ({1'b0, sel} < NV);

  always_comb begin
    mode_d    = mode_q;
    presc_d   = presc_q;
    dout_d    = dout_q;
    cur_sel_d = cur_sel_q;
    sel_err_d = sel_err_q;
    tick_d    = 1'b0;
    if (en) begin
      mode_d = mode_e'(mode);
      if (!mode) begin
        cur_sel_d = sel;
        if (sel_ok) begin
          dout_d    = pick(din, sel);
          sel_err_d = 1'b0;
        end else begin
          dout_d    = '0;
          sel_err_d = 1'b1;
        end
      end else if (mode_q == MODE_MANUAL) begin
        presc_d   = '0;
        cur_sel_d = '0;
        dout_d    = pick(din, '0);
        sel_err_d = 1'b0;
      end else begin
        sel_err_d = 1'b0;
        if (presc_q == PLAST) begin
          presc_d   = '0;
          cur_sel_d = (cur_sel_q == LAST) ? '0 : cur_sel_q + 1'b1;
          tick_d    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        dout_d = pick(din, cur_sel_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_MANUAL;
      presc_q   <= '0;
      dout_q    <= '0;
      cur_sel_q <= '0;
      sel_err_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      dout_q    <= dout_d;
      cur_sel_q <= cur_sel_d;
      sel_err_q <= sel_err_d;
      tick_q    <= tick_d;
    end
  end

  assign dout      = dout_q;
  assign cur_sel   = cur_sel_q;
  assign sel_err   = sel_err_q;
  assign scan_tick = tick_q;

`ifdef SCAN_ONEHOT_EN
  logic [N-1:0] an_n_q, an_n_d;

  always_comb begin
    an_n_d = an_n_q;
    if (en) begin
      an_n_d = '1;
      if (!sel_err_d)
        for (int unsigned k = 0; k < N; k++)
          if (cur_sel_d == SW'(k)) an_n_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) an_n_q <= '1;
    else        an_n_q <= an_n_d;
  end

  assign an_n = an_n_q;
`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed self-checking bench for mux_scan_n: an N=8/DIV=4 instance and an N=6/DIV=1 instance.
module tb_mux_scan_n;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [8*W-1:0] din;
  logic [5:0]     sel;
  logic           mode, en;
  logic [W-1:0]   dout;
  logic [5:0]     cur_sel;
  logic           sel_err, scan_tick;

  logic [6*W-1:0] din6;
  logic [2:0]     sel6;
  logic           mode6, en6;
  logic [W-1:0]   dout6;
  logic [2:0]     cur_sel6;
  logic           sel_err6, scan_tick6;

`ifdef SCAN_ONEHOT_EN
  logic [7:0] an_n;
  logic [5:0] an_n6;
`endif

  int checks = 0;
  int errors = 0;

  mux_scan_n #(.W(W), .N(8), .SW(6), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en(en),
    .dout(dout), .cur_sel(cur_sel), .sel_err(sel_err), .scan_tick(scan_tick)
`ifdef SCAN_ONEHOT_EN
    , .an_n(an_n)
`endif
  );

  mux_scan_n #(.W(W), .N(6), .SW(3), .DIV(1)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .mode(mode6), .en(en6),
    .dout(dout6), .cur_sel(cur_sel6), .sel_err(sel_err6), .scan_tick(scan_tick6)
`ifdef SCAN_ONEHOT_EN
    , .an_n(an_n6)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_index_data();
    for (int k = 0; k < 8; k++) din[k*W +: W] = 32'(k);
    for (int k = 0; k < 6; k++) din6[k*W +: W] = 32'(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = '0; din = '0;
    en6 = 1'b1; mode6 = 1'b0; sel6 = '0; din6 = '0;
    step();
    checks++;
    if (dout !== '0 || cur_sel !== '0 || sel_err !== 1'b0 || scan_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset8: got dout=%0h cur=%0d err=%b tick=%b expected 0 0 0 0", dout, cur_sel, sel_err, scan_tick);
    end
    checks++;
    if (dout6 !== '0 || cur_sel6 !== '0 || sel_err6 !== 1'b0 || scan_tick6 !== 1'b0) begin
      errors++;
      $display("FAIL reset6: got dout=%0h cur=%0d err=%b tick=%b expected 0 0 0 0", dout6, cur_sel6, sel_err6, scan_tick6);
    end
`ifdef SCAN_ONEHOT_EN
    checks++;
    if (an_n !== 8'hFF) begin
      errors++;
      $display("FAIL reset_an_n: got %b expected 11111111", an_n);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_manual_sweep();
    load_index_data();
    mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel = 6'(k);
      checks++;
      if (dout !== 32'(k == 0 ? 0 : k - 1)) begin
        errors++;
        $display("FAIL manual_latency k=%0d: got %0h expected %0h", k, dout, (k == 0 ? 0 : k - 1));
      end
      for (int c = 0; c < 5; c++) begin
        step();
        checks++;
        if (dout !== 32'(k) || cur_sel !== 6'(k) || sel_err !== 1'b0 || scan_tick !== 1'b0) begin
          errors++;
          $display("FAIL manual_sweep k=%0d c=%0d: got dout=%0h cur=%0d err=%b tick=%b expected %0h %0d 0 0",
                   k, c, dout, cur_sel, sel_err, scan_tick, k, k);
        end
      end
    end
  endtask

  task automatic test_pattern();
    for (int k = 0; k < 8; k++) din[k*W +: W] = (k % 2 == 0) ? 32'h5 : 32'hA;
    for (int k = 0; k < 8; k++) begin
      sel = 6'(k);
      step();
      checks++;
      if (dout !== ((k % 2 == 0) ? 32'h5 : 32'hA)) begin
        errors++;
        $display("FAIL pattern k=%0d: got %0h expected %0h", k, dout, (k % 2 == 0) ? 32'h5 : 32'hA);
      end
    end
  endtask

  task automatic test_scan();
    int exp_cur;
    load_index_data();
    mode = 1'b0; sel = 6'd5;
    step();
    mode = 1'b1;
    step();
    checks++;
    if (cur_sel !== 6'd0 || scan_tick !== 1'b0 || dout !== 32'd0) begin
      errors++;
      $display("FAIL scan_switch: got cur=%0d tick=%b dout=%0h expected 0 0 0", cur_sel, scan_tick, dout);
    end
    for (int i = 1; i <= 36; i++) begin
      step();
      exp_cur = (i / 4) % 8;
      checks++;
      if (cur_sel !== 6'(exp_cur) || scan_tick !== (i % 4 == 0) || dout !== 32'(exp_cur)) begin
        errors++;
        $display("FAIL scan i=%0d: got cur=%0d tick=%b dout=%0h expected %0d %b %0h",
                 i, cur_sel, scan_tick, dout, exp_cur, (i % 4 == 0), exp_cur);
      end
`ifdef SCAN_ONEHOT_EN
      checks++;
      if (an_n !== ~(8'h01 << exp_cur)) begin
        errors++;
        $display("FAIL onehot i=%0d: got %b expected %b", i, an_n, ~(8'h01 << exp_cur));
      end
`endif
    end
  endtask

  task automatic test_freeze_reset();
    mode = 1'b0;
    step();
    mode = 1'b1;
    step();
    for (int i = 0; i < 13; i++) step();
    checks++;
    if (cur_sel !== 6'd3) begin
      errors++;
      $display("FAIL freeze_start: got cur=%0d expected 3", cur_sel);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (cur_sel !== 6'd3 || scan_tick !== 1'b0 || dout !== 32'd3) begin
        errors++;
        $display("FAIL freeze i=%0d: got cur=%0d tick=%b dout=%0h expected 3 0 3", i, cur_sel, scan_tick, dout);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (cur_sel !== 6'(i == 3 ? 4 : 3) || scan_tick !== (i == 3)) begin
        errors++;
        $display("FAIL resume i=%0d: got cur=%0d tick=%b expected %0d %b", i, cur_sel, scan_tick, (i == 3 ? 4 : 3), (i == 3));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || cur_sel !== '0 || scan_tick !== 1'b0 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got dout=%0h cur=%0d tick=%b err=%b expected 0 0 0 0", dout, cur_sel, scan_tick, sel_err);
    end
    step();
    rst_n = 1'b1;
    din[0 +: W] = 32'h77;
    step();
    checks++;
    if (cur_sel !== 6'd0 || scan_tick !== 1'b0 || dout !== 32'h77) begin
      errors++;
      $display("FAIL post_reset_switch: got cur=%0d tick=%b dout=%0h expected 0 0 77", cur_sel, scan_tick, dout);
    end
  endtask

  task automatic test_out_of_range();
    load_index_data();
    mode6 = 1'b0; en6 = 1'b1; sel6 = 3'd7;
    step();
    checks++;
    if (dout6 !== '0 || sel_err6 !== 1'b1 || cur_sel6 !== 3'd7) begin
      errors++;
      $display("FAIL oor_sel7: got dout=%0h err=%b cur=%0d expected 0 1 7", dout6, sel_err6, cur_sel6);
    end
`ifdef SCAN_ONEHOT_EN
    checks++;
    if (an_n6 !== 6'b111111) begin
      errors++;
      $display("FAIL oor_an_n: got %b expected 111111", an_n6);
    end
`endif
    sel6 = 3'd2;
    step();
    checks++;
    if (dout6 !== 32'd2 || sel_err6 !== 1'b0 || cur_sel6 !== 3'd2) begin
      errors++;
      $display("FAIL oor_recover: got dout=%0h err=%b cur=%0d expected 2 0 2", dout6, sel_err6, cur_sel6);
    end
`ifdef SCAN_ONEHOT_EN
    checks++;
    if (an_n6 !== 6'b111011) begin
      errors++;
      $display("FAIL oor_recover_an_n: got %b expected 111011", an_n6);
    end
`endif
  endtask

  task automatic test_div1_wrap();
    mode6 = 1'b1;
    step();
    checks++;
    if (cur_sel6 !== 3'd0 || scan_tick6 !== 1'b0 || dout6 !== 32'd0 || sel_err6 !== 1'b0) begin
      errors++;
      $display("FAIL div1_switch: got cur=%0d tick=%b dout=%0h err=%b expected 0 0 0 0", cur_sel6, scan_tick6, dout6, sel_err6);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (cur_sel6 !== 3'(i % 6) || scan_tick6 !== 1'b1 || dout6 !== 32'(i % 6)) begin
        errors++;
        $display("FAIL div1 i=%0d: got cur=%0d tick=%b dout=%0h expected %0d 1 %0h", i, cur_sel6, scan_tick6, dout6, i % 6, i % 6);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual_sweep();
    test_pattern();
    test_scan();
    test_freeze_reset();
    test_out_of_range();
    test_div1_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
